// File: rtl/mem_responder_pkg.sv
// Shared configuration for the external memory responder: IO map, bus
// read/write encoding and the halt flag states.
package mem_responder_pkg;

    localparam logic [31:0] IO_BASE   = 32'h0003_0000;
    localparam logic [31:0] IO_UART   = 32'd0;
    localparam logic [31:0] IO_HALT   = 32'd4;

    localparam logic        RW_READ   = 1'b0;
    localparam logic        RW_WRITE  = 1'b1;

    localparam logic [7:0]  ZERO_BYTE = '0;

    typedef enum logic {
        HALT_RUN,
        HALT_HALTED
    } halt_state_e;

endpackage

// File: rtl/mem_responder_tx_fifo.sv
// Synchronous circular-buffer FIFO used as the TX byte queue; the head entry is
// read straight from storage, so a pushed byte shows up no earlier than the next cycle.
module sync_fifo_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_C);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    // A push into a full queue is still accepted when the head leaves this cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide RAM / memory-mapped IO responder on the external memory bus.
// Define MEM_INIT_EN to zero-initialise the RAM at elaboration.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = 17,
  parameter logic [31:0] IO_BASE   = mem_responder_pkg::IO_BASE,
  parameter int unsigned TX_DEPTH  = 8,
  parameter              INIT_FILE = "test.data"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_din,
  input  logic        in_wr,
  output logic [7:0]  dout,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        io_full,
  output logic        halt,
  output logic        tx_overflow
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(TX_DEPTH);

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              io_sel;
  logic              uart_sel;
  logic              halt_sel;
  logic              is_write;

  logic              tx_push_req;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;

  halt_state_e       halt_state;
  halt_state_e       halt_state_next;

`ifdef MEM_INIT_EN
  initial begin
    for (int unsigned i = 0; i < 2**RAM_AW; i++) begin
      ram[i] = ZERO_BYTE;
    end
  end
`endif

  assign ram_idx  = in_addr[RAM_AW-1:0];
  assign io_sel   = (in_addr >= IO_BASE);
  assign uart_sel = (in_addr == IO_BASE + IO_UART);
  assign halt_sel = (in_addr == IO_BASE + IO_HALT);
  assign is_write = (in_wr == RW_WRITE);

  assign rx_ready    = rx_valid & ~is_write & uart_sel;
  assign tx_push_req = is_write & uart_sel;
  assign tx_pop      = tx_ready & tx_valid;
  assign tx_valid    = ~tx_empty;
  assign io_full     = tx_full;

  always_ff @(posedge clk) begin
    if (is_write && !io_sel) begin
      ram[ram_idx] <= in_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= ZERO_BYTE;
    end else if (!is_write) begin
      if (!io_sel) begin
        dout <= ram[ram_idx];
      end else if (uart_sel && rx_valid) begin
        dout <= rx_data;
      end else begin
        dout <= ZERO_BYTE;
      end
    end
  end

  // A push is lost only when the queue is full and nothing drains this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_overflow <= 1'b0;
    end else if (tx_push_req && (tx_count == FULL_COUNT) && !tx_pop) begin
      tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_state <= HALT_RUN;
    end else begin
      halt_state <= halt_state_next;
    end
  end

  always_comb begin
    halt_state_next = halt_state;
    if (is_write && halt_sel) begin
      halt_state_next = HALT_HALTED;
    end
  end

  assign halt = (halt_state == HALT_HALTED);

  sync_fifo_tx #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push_req),
    .din   (in_din),
    .full  (tx_full),
    .pop   (tx_pop),
    .dout  (tx_data),
    .empty (tx_empty),
    .count (tx_count)
  );

endmodule
